// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Drives the shared PS2_CLK/PS2_DAT pins through open-drain enables. Pulses tx_done
// when the device ACKs the frame. Pulses tx_error on a NACK or a watchdog timeout.
// Optional feature macro: PS2_TX_RETRY_EN. When it is defined, a failed frame is
// re-sent up to MAX_RETRIES more times before tx_error is reported.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES    = 6000,
    parameter int unsigned REQ_CYCLES        = 16,
    parameter int unsigned FIRST_EDGE_CYCLES = 750000,
    parameter int unsigned EDGE_CYCLES       = 10000,
    parameter int unsigned MAX_RETRIES       = 2
) (
    input  logic       clock50,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] REQ_LAST     = 20'(REQ_CYCLES - 1);
    localparam logic [19:0] FIRST_LAST   = 20'(FIRST_EDGE_CYCLES - 1);
    localparam logic [19:0] EDGE_LAST    = 20'(EDGE_CYCLES - 1);
    localparam int          RW           = $clog2(MAX_RETRIES + 2);

`ifdef PS2_TX_RETRY_EN
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);
`else
    localparam logic [RW-1:0] RETRY_LIMIT = '0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_WAIT_IDLE
    } state_t;

    state_t        state, state_next;
    logic [19:0]   cnt, cnt_next;
    logic [3:0]    bit_cnt, bit_cnt_next;
    logic [RW-1:0] retry_cnt, retry_next;
    logic [7:0]    data, data_next;
    logic          parity, parity_next;
    logic          clk_oe_next, dat_oe_next;
    logic          done_next, error_next, ready_next, busy_next;
    logic          nack, timeout;

    // Synchronizer pipeline for the asynchronous pin levels
    logic clk_p0, clk_p1, clk_p2;
    logic dat_p0, dat_p1;
    logic clk_fall;

    assign clk_fall = clk_p2 & ~clk_p1;

    // Saturating increment: the watchdog must never wrap back below its limit
    function automatic logic [19:0] sat_inc(input logic [19:0] v);
        return (v == 20'hFFFFF) ? v : v + 20'd1;
    endfunction

    // Frame bit on the wire after fall n. Fall 0 is the start bit, falls 1..8 carry
    // the data LSB first, fall 9 is parity, and anything later is the stop bit.
    function automatic logic frame_bit(input logic [7:0] d, input logic p,
                                       input logic [3:0] n);
        logic       b;
        logic [3:0] k;
        b = 1'b1;
        k = n - 4'd1;
        if (n == 4'd0)
            b = 1'b0;
        else if (n <= 4'd8)
            b = d[k[2:0]];
        else if (n == 4'd9)
            b = p;
        return b;
    endfunction

    // Two-flop synchronizers. Both lines reset high (idle) so reset cannot create a fall.
    always_ff @(posedge clock50 or negedge reset) begin
        if (!reset) begin
            clk_p0 <= 1'b1;
            clk_p1 <= 1'b1;
            clk_p2 <= 1'b1;
            dat_p0 <= 1'b1;
            dat_p1 <= 1'b1;
        end else begin
            clk_p0 <= ps2_clk_in;
            clk_p1 <= clk_p0;
            clk_p2 <= clk_p1;
            dat_p0 <= ps2_dat_in;
            dat_p1 <= dat_p0;
        end
    end

    // State, counters and registered outputs. The latched byte and its parity are not reset.
    always_ff @(posedge clock50 or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            retry_cnt  <= '0;
            tx_ready   <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            busy       <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            bit_cnt    <= bit_cnt_next;
            retry_cnt  <= retry_next;
            tx_ready   <= ready_next;
            tx_done    <= done_next;
            tx_error   <= error_next;
            busy       <= busy_next;
            ps2_clk_oe <= clk_oe_next;
            ps2_dat_oe <= dat_oe_next;
        end
    end

    // Command byte and parity are captured when a request is accepted
    always_ff @(posedge clock50) begin
        data   <= data_next;
        parity <= parity_next;
    end

    // Next-state logic: the frame sequencer, the watchdog, and the retry decision
    always_comb begin
        state_next   = state;
        cnt_next     = sat_inc(cnt);
        bit_cnt_next = bit_cnt;
        retry_next   = retry_cnt;
        data_next    = data;
        parity_next  = parity;
        clk_oe_next  = 1'b0;
        dat_oe_next  = 1'b0;
        done_next    = 1'b0;
        error_next   = 1'b0;
        nack         = 1'b0;
        timeout      = 1'b0;

        case (state)
            S_IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_next  = S_INHIBIT;
                    cnt_next    = '0;
                    data_next   = tx_data;
                    parity_next = ~^tx_data;
                    retry_next  = '0;
                    clk_oe_next = 1'b1;
                end
            end
            S_INHIBIT: begin
                clk_oe_next = 1'b1;
                if (cnt >= INHIBIT_LAST) begin
                    state_next  = S_REQ;
                    cnt_next    = '0;
                    dat_oe_next = 1'b1;
                end
            end
            S_REQ: begin
                clk_oe_next = 1'b1;
                dat_oe_next = 1'b1;
                if (cnt >= REQ_LAST) begin
                    state_next   = S_SEND;
                    cnt_next     = '0;
                    bit_cnt_next = '0;
                    clk_oe_next  = 1'b0;
                end
            end
            S_SEND: begin
                dat_oe_next = ~frame_bit(data, parity, bit_cnt);
                if (clk_fall) begin
                    cnt_next     = '0;
                    bit_cnt_next = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd10) begin
                        dat_oe_next = 1'b0;
                        if (!dat_p1) begin
                            done_next  = 1'b1;
                            state_next = S_WAIT_IDLE;
                        end else begin
                            nack = 1'b1;
                        end
                    end else begin
                        dat_oe_next = ~frame_bit(data, parity, bit_cnt + 4'd1);
                    end
                end else if ((bit_cnt == 4'd0 && cnt >= FIRST_LAST) ||
                             (bit_cnt != 4'd0 && cnt >= EDGE_LAST)) begin
                    timeout = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if ((clk_p1 && dat_p1) || cnt >= EDGE_LAST)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        if (nack || timeout) begin
            cnt_next = '0;
            if (retry_cnt != RETRY_LIMIT) begin
                state_next  = S_INHIBIT;
                retry_next  = retry_cnt + 1'b1;
                clk_oe_next = 1'b1;
                dat_oe_next = 1'b0;
            end else begin
                state_next  = nack ? S_WAIT_IDLE : S_IDLE;
                error_next  = 1'b1;
                clk_oe_next = 1'b0;
                dat_oe_next = 1'b0;
            end
        end

        ready_next = (state_next == S_IDLE);
        busy_next  = (state_next != S_IDLE);
    end

endmodule
